// File: rtl/reg_file_sb.sv
// Parametrised register file with lane-selective write-back, same-cycle forwarding
// and a per-register pending-write scoreboard for RAW hazard detection.
module reg_file_sb #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [2:0]               ppp,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int CW = ADDR_W + 1;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [DATA_W-1:0]   wmask;
  logic [DATA_W-1:0]   merged;
  logic                write_hit;
  logic                rsv_hit;
  logic                cnt_inc;
  logic                cnt_dec;

  assign write_hit = wr_en && (in_addr != '0);
  assign rsv_hit   = rsv_en && (rsv_addr != '0);

  // Bit 0 is the MSB, so lane j of the architectural view is byte DATA_W/8-1-j here.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      case (ppp)
        3'b000:  wmask[i] = 1'b1;
        3'b001:  wmask[i] = (i >= DATA_W/2);
        3'b010:  wmask[i] = (i < DATA_W/2);
        3'b011:  wmask[i] = ((((DATA_W-1-i)/8) % 2) == 0);
        3'b100:  wmask[i] = ((((DATA_W-1-i)/8) % 2) == 1);
        default: wmask[i] = 1'b0;
      endcase
    end
  end

  assign merged = (regs[in_addr] & ~wmask) | (in_data & wmask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_hit) begin
      regs[in_addr] <= merged;
    end
  end

  // Count tracks the popcount of pend; a same-address reserve overrides the clear.
  assign cnt_inc = rsv_hit && !pend[rsv_addr];
  assign cnt_dec = write_hit && pend[in_addr] && !(rsv_hit && (rsv_addr == in_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (write_hit) pend[in_addr] <= 1'b0;
      if (rsv_hit)   pend[rsv_addr] <= 1'b1;
      pend_cnt <= pend_cnt + CW'(cnt_inc) - CW'(cnt_dec);
    end
  end

  // Port 0 occupies the most significant slice of every packed port bus.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    localparam int S = NUM_RD - 1 - k;
    logic [ADDR_W-1:0] addr;
    logic              fwd;

    assign addr = rd_addr[S*ADDR_W +: ADDR_W];
    assign fwd  = write_hit && (in_addr == addr);
    assign rd_data[S*DATA_W +: DATA_W] = rst ? '0 : (fwd ? merged : regs[addr]);
    assign rd_busy[S] = !rst && pend[addr] && !(wr_en && (in_addr == addr));
  end

endmodule
